l2_bus_arbiter: RTL

Two-master arbiter between the L1 caches (master 0 = I-cache, master 1 = D-cache) and the single-ported L2 memory. Each cache's miss path raises `mem_en`/`mem_wr_en` and waits for its `rd_granted`/`wr_granted`. The arbiter then grants one master for a whole transfer: a BURST_LEN-word line fill for reads, or a single-word write-through for writes. While granted, the owner's address and data go to L2, and read data returns to the caches.

---
 rtl/l2_bus_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/l2_bus_arbiter.sv
// rtl/l2_bus_arbiter.sv - two-master L1-to-L2 burst arbiter; L2_ARB_FIXED_PRIO_EN selects fixed priority (master 1 wins ties)
module l2_bus_arbiter #(
    parameter int BURST_LEN = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_mem_en,
    input  logic        m1_mem_en,
    input  logic        m0_mem_wr_en,
    input  logic        m1_mem_wr_en,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wr_data,
    input  logic [31:0] m1_wr_data,
    output logic        m0_rd_granted,
    output logic        m1_rd_granted,
    output logic        m0_wr_granted,
    output logic        m1_wr_granted,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic [31:0] mx_rd_data,
    output logic        l2_req,
    output logic        l2_we,
    output logic [31:0] l2_addr,
    output logic [31:0] l2_wdata,
    input  logic [31:0] l2_rdata,
    input  logic        l2_ack
);
    localparam int CW = $clog2(BURST_LEN) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN0 = 2'd1;
    localparam logic [1:0] S_OWN1 = 2'd2;
    localparam logic [1:0] S_REL  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          is_wr_q, is_wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owning, own_sel, own_en, last_beat, release_w, pick1;

    assign owning    = (state_q == S_OWN0) || (state_q == S_OWN1);
    assign own_sel   = (state_q == S_OWN1);
    assign own_en    = own_sel ? m1_mem_en : m0_mem_en;
    assign last_beat = is_wr_q ? (cnt_q == CW'(0)) : (cnt_q == CW'(BURST_LEN - 1));
    // Ownership ends on the final beat's ack or when the owner abandons its request.
    assign release_w = owning && (!own_en || (l2_ack && last_beat));

`ifdef L2_ARB_FIXED_PRIO_EN
    assign pick1 = m1_mem_en;
`else
    logic rr_q, rr_d;

    // rr_q remembers the last owner; the other master wins a tie.
    assign pick1 = m1_mem_en && (!m0_mem_en || !rr_q);
    assign rr_d  = release_w ? own_sel : rr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b1;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        is_wr_d = is_wr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (m0_mem_en || m1_mem_en) begin
                    state_d = pick1 ? S_OWN1 : S_OWN0;
                    is_wr_d = pick1 ? m1_mem_wr_en : m0_mem_wr_en;
                    cnt_d   = '0;
                end
            end
            S_OWN0, S_OWN1: begin
                if (own_en && l2_ack) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (release_w) begin
                    state_d = S_REL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            is_wr_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            is_wr_q <= is_wr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign m0_rd_granted = (state_q == S_OWN0) && !is_wr_q;
    assign m0_wr_granted = (state_q == S_OWN0) && is_wr_q;
    assign m1_rd_granted = (state_q == S_OWN1) && !is_wr_q;
    assign m1_wr_granted = (state_q == S_OWN1) && is_wr_q;

    assign m0_ack     = (state_q == S_OWN0) && m0_mem_en && l2_ack;
    assign m1_ack     = (state_q == S_OWN1) && m1_mem_en && l2_ack;
    assign mx_rd_data = l2_rdata;

    assign l2_req   = owning && own_en;
    assign l2_we    = owning && is_wr_q;
    assign l2_addr  = owning ? (own_sel ? m1_addr : m0_addr) : 32'd0;
    assign l2_wdata = owning ? (own_sel ? m1_wr_data : m0_wr_data) : 32'd0;
endmodule
